// File: rtl/spi_i2c_pkg.sv
// spi_i2c_pkg: shared types and constants for the spitoi2c bridge scheduler
package spi_i2c_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
  localparam int BYTE_W = 8;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_GAP_CYCLES = 8;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request after ptr with wrap
module rr_arbiter import spi_i2c_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [idx_w(N)-1:0]   grant,
  output logic                  valid
);
  localparam int IW = idx_w(N);
  logic [IW-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      grant = req[idx] ? idx : grant;
    end
    valid = |req;
  end
endmodule

// File: rtl/spi_i2c_bridge_sched.sv
// spi_i2c_bridge_sched: round-robin sharing of one spitoi2c bridge among N byte requesters
module spi_i2c_bridge_sched import spi_i2c_pkg::*; #(
  parameter int N = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [BYTE_W*N-1:0]   req_data,
  output logic [N-1:0]          ack,
  output logic [N-1:0]          err,
  output logic                  busy,
  output logic [idx_w(N)-1:0]   grant_id,
  output logic                  bridge_start,
  output logic [BYTE_W-1:0]     bridge_data,
  input  logic                  bridge_done
);
  localparam int IW = idx_w(N);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic pick_v;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  rr_arbiter #(.N(N)) u_arb (.req(req), .ptr(ptr), .grant(pick), .valid(pick_v));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack <= '0;
      err <= '0;
      busy <= 1'b0;
      bridge_start <= 1'b0;
      bridge_data <= '0;
      grant_id <= '0;
      ptr <= IW'(N - 1);
      tcnt <= '0;
      gcnt <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: if (pick_v) begin
          grant_id <= pick;
          ptr <= pick;
          bridge_data <= req_data[pick*BYTE_W +: BYTE_W];
          bridge_start <= 1'b1;
          busy <= 1'b1;
          tcnt <= '0;
          state <= WAIT;
        end
        // completion beats a timeout landing on the same edge
        WAIT: if (bridge_done) begin
          ack[grant_id] <= 1'b1;
          bridge_start <= 1'b0;
          gcnt <= '0;
          state <= GAP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err[grant_id] <= 1'b1;
          bridge_start <= 1'b0;
          gcnt <= '0;
          state <= GAP;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          gcnt <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_i2c_bridge_sched.sv
// tb_spi_i2c_bridge_sched: randomized scoreboard bench with a transaction-level scheduler model
module tb_spi_i2c_bridge_sched;
  import spi_i2c_pkg::*;
  localparam int N = 4;
  localparam int TO = 24;
  localparam int GAP = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] ack, err;
  logic busy, bridge_start;
  logic bridge_done = 1'b0;
  logic [1:0] grant_id;
  logic [7:0] bridge_data;
  int checks = 0;
  int errors = 0;
  typedef struct {int id; logic [7:0] data; int dly;} xfer_t;
  xfer_t expq[$];
  int dq[$];
  int mptr = N - 1;
  bit m_prev, m_inx, m_gap, m_ackok;
  int m_c, m_t0, m_g;
  int m_last = -1000;
  xfer_t m_e;
  bit r_prev, r_act;
  int r_d, r_k;

  spi_i2c_bridge_sched #(.N(N), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .busy(busy), .grant_id(grant_id), .bridge_start(bridge_start),
    .bridge_data(bridge_data), .bridge_done(bridge_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rand_dly();
    int r = $urandom_range(0, 9);
    return r == 0 ? 0 : r == 1 ? TO : $urandom_range(1, TO + 2);
  endfunction

  // Bridge responder: completes each transfer after its scheduled delay (0 = never),
  // drops requests on their ack/err, and injects stray done pulses while start is low.
  initial begin
    forever begin
      @(negedge clk);
      bridge_done = 1'b0;
      req = req & ~(ack | err);
      if (reset) begin
        r_act = 0;
        r_prev = 0;
      end else begin
        if (bridge_start && !r_prev) begin
          r_d = dq.size() > 0 ? dq.pop_front() : 0;
          r_k = 0;
          r_act = 1;
        end
        r_prev = bridge_start;
        if (r_act && !bridge_start) r_act = 0;
        if (r_act) begin
          if (r_d != 0 && r_k == r_d - 1) begin
            bridge_done = 1'b1;
            r_act = 0;
          end
          r_k++;
        end else if (!bridge_start && $urandom_range(0, 5) == 0) begin
          bridge_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the expected transfer on each start, then checks result and gap.
  initial begin
    forever begin
      @(negedge clk);
      m_c++;
      if (reset) begin
        m_prev = 0;
        m_inx = 0;
        m_gap = 0;
        m_last = -1000;
      end else begin
        if (bridge_start && !m_prev) begin
          if (expq.size() == 0) chk("unexpected_start", 1, 0);
          else begin
            m_e = expq.pop_front();
            chk("grant_id", 32'(grant_id), m_e.id);
            chk("bridge_data", 32'(bridge_data), 32'(m_e.data));
            chk("busy_at_start", 32'(busy), 1);
            chk("start_spacing", 32'((m_c - m_last) >= GAP + 1), 1);
            m_last = m_c;
            m_t0 = m_c;
            m_inx = 1;
          end
        end
        m_prev = bridge_start;
        if ((ack | err) != 0) begin
          chk("pulse_onehot", $countones({ack, err}), 1);
          if (!m_inx) chk("unsolicited_pulse", 32'(ack | err), 0);
          else begin
            m_ackok = m_e.dly != 0 && m_e.dly <= TO;
            chk("ack", 32'(ack), m_ackok ? 32'(1 << m_e.id) : 0);
            chk("err", 32'(err), m_ackok ? 0 : 32'(1 << m_e.id));
            chk("latency", m_c - m_t0, m_ackok ? m_e.dly : TO);
            chk("start_dropped", 32'(bridge_start), 0);
            chk("busy_at_result", 32'(busy), 1);
            m_inx = 0;
            m_gap = 1;
            m_g = 1;
          end
        end else if (m_inx && m_c - m_t0 > TO + 2) begin
          chk("result_timeout", 1, 0);
          m_inx = 0;
        end else if (m_gap) begin
          if (busy) begin
            m_g++;
            if (m_g > GAP + 2) begin
              chk("gap_len", m_g, GAP);
              m_gap = 0;
            end
          end else begin
            chk("gap_len", m_g, GAP);
            m_gap = 0;
          end
        end
      end
    end
  end

  // All requesters in mask stay up until served, so they are granted in circular
  // order starting after the last granted index.
  task automatic run_batch(input logic [N-1:0] mask, input logic [8*N-1:0] data, input int dly);
    int last_id = mptr;
    int d;
    for (int k = 1; k <= N; k++) begin
      int i = (mptr + k) % N;
      if (mask[i]) begin
        d = dly >= 0 ? dly : rand_dly();
        expq.push_back('{i, data[8*i +: 8], d});
        dq.push_back(d);
        last_id = i;
      end
    end
    mptr = last_id;
    @(negedge clk);
    req_data = data;
    req = mask;
    for (int w = 0; w < (TO + GAP + 4) * N + 10 && (req != 0 || busy); w++) @(negedge clk);
    chk("batch_drained", {27'd0, req, busy}, 0);
    chk("idle_start_low", 32'(bridge_start), 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(bridge_start), 0);
    chk("rst_data", 32'(bridge_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    reset = 1'b0;
    run_batch(4'b0001, 32'h000000AD, 20);
    run_batch(4'b1111, 32'h44332211, 5);
    run_batch(4'b0100, 32'h005A0000, 0);
    run_batch(4'b0010, 32'h0000BB00, TO);
    repeat (40) run_batch(N'($urandom_range(1, 15)), $urandom(), -1);
    expq.push_back('{0, 8'h77, 0});
    dq.push_back(0);
    @(negedge clk);
    req_data = 32'h00000077;
    req = 4'b0001;
    for (int w = 0; w < 5 && !bridge_start; w++) @(negedge clk);
    chk("mid_start", 32'(bridge_start), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk("mid_rst_start", 32'(bridge_start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pulses", 32'(ack | err), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    reset = 1'b0;
    mptr = N - 1;
    run_batch(4'b1010, 32'hCC00DD00, -1);
    chk("queues_empty", expq.size() + dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
